phase_sequencer: RTL
====================

Name: phase_sequencer

Overview:
- Five-phase instruction sequencer for the 16-bit simple CPU. Generates the 3-bit `state` bus that activates each datapath stage; the register file reads operands on 3'b010 and writes back on 3'b101.
- Handles run/stop control, the HLT instruction, memory-wait stalls with timeout, and retired-instruction counting.

Parameters:
- CNT_W, 16, width of instr_count.
- MAX_WAIT, 15, maximum consecutive P4 stall cycles before ERROR; legal range 1..255.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
- start  in  1  level-sampled request to begin or resume execution.
- stop  in  1  request to stop at the next instruction boundary.
- halt  in  1  HLT decoded from IR; sampled only in P5.
- mem_wait  in  1  memory not ready; sampled only in P4.
- state  out  3  current phase: 000 IDLE, 001 P1, 010 P2, 011 P3, 100 P4, 101 P5, 110 HALT, 111 ERROR.
- running  out  1  1 while state is P1..P5.
- halted  out  1  1 while state is HALT.
- error  out  1  1 while state is ERROR.
- ir_load  out  1  1 while state is P1.
- pc_write  out  1  1 while state is P5.
- reg_write_en  out  1  1 while state is P5.
- instr_count  out  CNT_W  number of retired instructions.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, instr_count=0, wait_cnt=0, stop_pending=0. All decoded outputs are therefore 0.
- Decoded outputs (running, halted, error, ir_load, pc_write, reg_write_en) are combinational decodes of the state register only. There is no input-to-output combinational path.
- IDLE: start=1 -> P1; otherwise stay. stop is ignored in IDLE. If start and stop are both 1, go to P1 and do not set stop_pending.
- P1 -> P2 -> P3 -> P4 unconditionally, one cycle each.
- P4 with mem_wait=0 -> P5 and clear wait_cnt.
- P4 with mem_wait=1 -> stay in P4 and increment wait_cnt. If wait_cnt==MAX_WAIT-1 and mem_wait=1 in that cycle, go to ERROR instead. Result: at most MAX_WAIT stall cycles; ERROR is entered on stall cycle MAX_WAIT.
- P5: instr_count increments by 1 and wraps modulo 2^CNT_W. Next state is chosen by priority:
  1. halt=1 -> HALT.
  2. stop_pending=1 or stop=1 -> IDLE.
  3. Otherwise -> P1.
- stop_pending is set by stop=1 in any of P1..P4 and cleared on entry to IDLE or HALT.
- HALT: start=1 -> P1, resuming at the next PC; instr_count is preserved. stop is ignored.
- ERROR: sticky; only reset exits. instr_count is frozen.
- start while in P1..P5 is ignored.
- Minimum instruction latency: 5 cycles from P1 entry to P1 re-entry. Each stall cycle adds 1.
- Reset asserted mid-instruction aborts it with no retirement count.

Optional Feature:
- Macro SINGLE_STEP_EN.
- When defined:
  - Adds input port `step_mode` (1 bit).
  - In P5 with halt=0 and step_mode=1, the next state is IDLE. Each start pulse then executes exactly one instruction.
  - halt still takes priority (HALT).
- When undefined:
  - The step_mode port does not exist.
  - P5 behaves exactly as in the base description.

Test Plan:
- Release reset, start=1 for 1 cycle, mem_wait=0 -> state sequence 001,010,011,100,101,001 continuing; instr_count=1 at cycle 6 after start.
- mem_wait=1 for 3 cycles in P4 -> state holds 100 for 4 cycles total, then 101. With MAX_WAIT=15 and mem_wait held 15 cycles -> state=111, error=1, persists until reset.
- stop pulsed during P2 of instruction N -> P5 of N then 000; instr_count=N. Next start -> P1.
- halt=1 in P5 -> state=110, halted=1. start -> 001 with instr_count unchanged; CNT_W=4 after 16 retirements -> instr_count=0.
- reset pulled low during P3 -> state=000 and instr_count=0 immediately, without waiting for a clock edge.
- With SINGLE_STEP_EN and step_mode=1: each start pulse -> exactly P1..P5 then 000; instr_count +1 per pulse.

Source files
------------

// File: rtl/phase_sequencer.sv
// Five-phase instruction sequencer: run/stop control, HLT, memory-wait stalls with timeout, retire count.
// Optional build macro SINGLE_STEP_EN adds a step_mode input that returns to IDLE after every instruction.
module phase_sequencer #(
   parameter int CNT_W    = 16,
   parameter int MAX_WAIT = 15
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             halt,
   input  logic             mem_wait,
`ifdef SINGLE_STEP_EN
   input  logic             step_mode,
`endif
   output logic [2:0]       state,
   output logic             running,
   output logic             halted,
   output logic             error,
   output logic             ir_load,
   output logic             pc_write,
   output logic             reg_write_en,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'b000,
      S_P1    = 3'b001,
      S_P2    = 3'b010,
      S_P3    = 3'b011,
      S_P4    = 3'b100,
      S_P5    = 3'b101,
      S_HALT  = 3'b110,
      S_ERROR = 3'b111
   } state_t;

   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [7:0]       wait_q, wait_d;
   logic             pend_q, pend_d;
   logic             step_stop;

`ifdef SINGLE_STEP_EN
   assign step_stop = step_mode;
`else
   assign step_stop = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         count_q <= '0;
         wait_q  <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         wait_q  <= wait_d;
         pend_q  <= pend_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      wait_d  = wait_q;
      pend_d  = pend_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_P1;
         S_P1:    state_d = S_P2;
         S_P2:    state_d = S_P3;
         S_P3:    state_d = S_P4;
         S_P4: begin
            if (!mem_wait) begin
               state_d = S_P5;
               wait_d  = '0;
            end else if (wait_q == WAIT_LAST) begin
               state_d = S_ERROR;
            end else begin
               wait_d  = wait_q + 8'd1;
            end
         end
         S_P5: begin
            count_d = count_q + CNT_W'(1);
            if (halt)                              state_d = S_HALT;
            else if (pend_q || stop || step_stop)  state_d = S_IDLE;
            else                                   state_d = S_P1;
         end
         S_HALT:  if (start) state_d = S_P1;
         default: state_d = S_ERROR;
      endcase

      // A stop seen mid-instruction is remembered until the instruction boundary.
      if (stop && (state_q inside {S_P1, S_P2, S_P3, S_P4})) pend_d = 1'b1;
      if (state_d == S_IDLE || state_d == S_HALT)            pend_d = 1'b0;
   end

   assign state        = state_q;
   assign running      = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_ERROR);
   assign halted       = (state_q == S_HALT);
   assign error        = (state_q == S_ERROR);
   assign ir_load      = (state_q == S_P1);
   assign pc_write     = (state_q == S_P5);
   assign reg_write_en = (state_q == S_P5);
   assign instr_count  = count_q;

endmodule
